spi_target_ctrl: RTL and testbench



---
 rtl/spi_target_pkg.sv | 23 ++
 rtl/spi_target_ctrl_if.sv | 21 ++
 rtl/spi_target_fifo.sv | 60 ++++++
 rtl/spi_target_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_spi_target_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target peripheral:
// register map, status bit positions and the RX FIFO entry.
package spi_target_pkg;

    localparam logic [7:0] REG_STATUS = 8'h00;
    localparam logic [7:0] REG_RXDATA = 8'h04;
    localparam logic [7:0] REG_TXDATA = 8'h08;
    localparam logic [7:0] REG_MODE   = 8'h0C;

    localparam int ST_OVF = 8;
    localparam int ST_UDR = 9;
    localparam int ST_PRT = 10;
    localparam int ST_TXV = 11;
    localparam int ST_CSA = 12;

    localparam logic [31:0] RX_EMPTY_FLAG = 32'h8000_0000;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } rx_entry_t;

endpackage

// File: rtl/spi_target_ctrl_if.sv
// icosoc ctrl bus: request held by master until a one-cycle done.
interface spi_target_ctrl_if;

    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        done;

    modport master (
        output wr, rd, addr, wdat,
        input  rdat, done
    );

    modport slave (
        input  wr, rd, addr, wdat,
        output rdat, done
    );

endinterface

// File: rtl/spi_target_fifo.sv
// Synchronous first-word-fall-through FIFO of received entries.
module spi_target_fifo
    import spi_target_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  rx_entry_t     wdata,
    output rx_entry_t     rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    rx_entry_t         mem [DEPTH];
    logic [AW-1:0]     wp;
    logic [AW-1:0]     rp;
    logic              do_push;
    logic              do_pop;

    // A pop frees the slot being written, so push is legal when full.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + AW'(1);
            end
            if (do_pop) begin
                rp <= rp + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_target_ctrl.sv
// SPI target on the ctrl bus: oversampled sclk/mosi/cs/dc,
// RX FIFO of {dc, byte}, single-byte TX buffer onto miso.
module spi_target_ctrl
    import spi_target_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    spi_target_ctrl_if.slave  ctrl,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_cs,
    input  logic              spi_dc,
    output logic              spi_miso,
    output logic              spi_miso_oe
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [SYNC_STAGES-1:0] sclk_sy;
    logic [SYNC_STAGES-1:0] mosi_sy;
    logic [SYNC_STAGES-1:0] cs_sy;
    logic [SYNC_STAGES-1:0] dc_sy;
    logic sclk_s, mosi_s, cs_s, dc_s;
    logic sclk_q, cs_q;

    logic       cpol, cpha;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sh;
    logic [7:0] tx_sh;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_skip;
    logic       ovf, udr, prt;

    logic cs_act, cs_fall, cs_rise;
    logic rise, fall, lead, trail;
    logic smp, shf, last, bound;
    logic [7:0] tx_load;

    rx_entry_t     push_d;
    rx_entry_t     pop_d;
    logic          pop, full, empty;
    logic [CW-1:0] count;
    logic [8:0]    cnt9;

    logic        req_new, do_wr, do_rd;
    logic [31:0] status;
    logic [31:0] rd_val;
    logic        unused_bits;

    assign sclk_s = sclk_sy[SYNC_STAGES-1];
    assign mosi_s = mosi_sy[SYNC_STAGES-1];
    assign cs_s   = cs_sy[SYNC_STAGES-1];
    assign dc_s   = dc_sy[SYNC_STAGES-1];

    assign cs_act  = ~cs_s;
    assign cs_fall = cs_q & ~cs_s;
    assign cs_rise = ~cs_q & cs_s;

    assign rise  = sclk_s & ~sclk_q;
    assign fall  = ~sclk_s & sclk_q;
    assign lead  = cpol ? fall : rise;
    assign trail = cpol ? rise : fall;
    assign smp   = cs_act & (cpha ? trail : lead);
    assign shf   = cs_act & (cpha ? lead : trail);
    assign last  = smp & (bit_cnt == 3'd7);
    assign bound = cs_fall | last;

    assign tx_load = tx_valid ? tx_data : 8'hFF;

    assign push_d.dc   = dc_s;
    assign push_d.data = {rx_sh, mosi_s};

    assign req_new = (ctrl.wr | ctrl.rd) & ~ctrl.done;
    assign do_wr   = req_new & ctrl.wr;
    assign do_rd   = req_new & ~ctrl.wr;
    assign pop     = do_rd & (ctrl.addr == REG_RXDATA) & ~empty;

    assign spi_miso_oe = cs_act;

    assign cnt9        = 9'(count);
    assign unused_bits = ^{ctrl.wdat[31:11], cnt9[8]};

    spi_target_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (last),
        .pop   (pop),
        .wdata (push_d),
        .rdata (pop_d),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        status         = '0;
        status[7:0]    = cnt9[7:0];
        status[ST_OVF] = ovf;
        status[ST_UDR] = udr;
        status[ST_PRT] = prt;
        status[ST_TXV] = tx_valid;
        status[ST_CSA] = cs_act;
    end

    always_comb begin
        rd_val = '0;
        case (ctrl.addr)
            REG_STATUS: rd_val = status;
            REG_RXDATA: rd_val = empty ? RX_EMPTY_FLAG
                                       : {23'b0, pop_d};
            REG_MODE:   rd_val = {30'b0, cpol, cpha};
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sy <= '1;
            cs_sy   <= '1;
            mosi_sy <= '0;
            dc_sy   <= '0;
        end else begin
            sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], spi_sclk};
            cs_sy   <= {cs_sy[SYNC_STAGES-2:0], spi_cs};
            mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], spi_mosi};
            dc_sy   <= {dc_sy[SYNC_STAGES-2:0], spi_dc};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_q    <= 1'b1;
            cs_q      <= 1'b1;
            cpol      <= 1'b1;
            cpha      <= 1'b1;
            bit_cnt   <= '0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            tx_skip   <= 1'b0;
            ovf       <= 1'b0;
            udr       <= 1'b0;
            prt       <= 1'b0;
            spi_miso  <= 1'b0;
            ctrl.done <= 1'b0;
            ctrl.rdat <= '0;
        end else begin
            sclk_q <= sclk_s;
            cs_q   <= cs_s;

            // Clear first so a flag raised this cycle survives.
            if (do_wr && ctrl.addr == REG_STATUS) begin
                if (ctrl.wdat[ST_OVF]) ovf <= 1'b0;
                if (ctrl.wdat[ST_UDR]) udr <= 1'b0;
                if (ctrl.wdat[ST_PRT]) prt <= 1'b0;
            end

            if (cs_fall) begin
                bit_cnt <= '0;
            end else if (cs_rise) begin
                if (bit_cnt != 3'd0) prt <= 1'b1;
                bit_cnt <= '0;
            end else if (smp) begin
                rx_sh   <= {rx_sh[5:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (last && full && !pop) begin
                ovf <= 1'b1;
            end

            // cpha=0 drives the MSB at the boundary, so the trailing
            // edge that closes the previous byte must not advance.
            if (bound) begin
                if (tx_valid) tx_valid <= 1'b0;
                else          udr      <= 1'b1;
                if (cpha) begin
                    tx_sh   <= tx_load;
                    tx_skip <= 1'b0;
                end else begin
                    spi_miso <= tx_load[7];
                    tx_sh    <= {tx_load[6:0], 1'b0};
                    tx_skip  <= last;
                end
            end else if (shf) begin
                if (tx_skip) begin
                    tx_skip <= 1'b0;
                end else begin
                    spi_miso <= tx_sh[7];
                    tx_sh    <= {tx_sh[6:0], 1'b0};
                end
            end

            if (do_wr && ctrl.addr == REG_TXDATA) begin
                tx_data  <= ctrl.wdat[7:0];
                tx_valid <= 1'b1;
            end
            if (do_wr && ctrl.addr == REG_MODE) begin
                cpol <= ctrl.wdat[1];
                cpha <= ctrl.wdat[0];
            end

            ctrl.done <= req_new;
            ctrl.rdat <= do_rd ? rd_val : '0;
        end
    end

endmodule

// File: tb/tb_spi_target_ctrl.sv
// Directed bench: bus tasks plus a bit-banged SPI master model.
module tb_spi_target_ctrl;
    import spi_target_pkg::*;

    localparam int H = 8;

    logic clk = 1'b0;
    logic reset;
    logic sclk, mosi, cs, dc;
    logic miso, miso_oe;
    logic cpol_m, cpha_m;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [31:0] q;
    logic [7:0]  rx;
    logic [31:0] ppq;
    logic        ppd;

    spi_target_ctrl_if bus ();

    spi_target_ctrl #(
        .FIFO_DEPTH  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ctrl        (bus),
        .spi_sclk    (sclk),
        .spi_mosi    (mosi),
        .spi_cs      (cs),
        .spi_dc      (dc),
        .spi_miso    (miso),
        .spi_miso_oe (miso_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_xact(input logic w, input logic r,
                            input logic [7:0] a, input logic [31:0] d,
                            output logic [31:0] rq);
        bit ok = 1'b0;
        rq = 'x;
        @(negedge clk);
        bus.wr = w; bus.rd = r; bus.addr = a; bus.wdat = d;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                ok = 1'b1;
                rq = bus.rdat;
            end
        end
        bus.wr = 1'b0; bus.rd = 1'b0;
        if (!ok) chk("bus_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus_xact(1'b1, 1'b0, a, d, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a,
                          input logic [31:0] exp);
        logic [31:0] r;
        bus_xact(1'b0, 1'b1, a, 32'd0, r);
        chk(tag, r, exp);
    endtask

    task automatic cs_lo();
        cs = 1'b0;
        wait_n(H);
    endtask

    task automatic cs_hi();
        wait_n(H);
        cs = 1'b1;
        wait_n(H);
    endtask

    // Optional pp: issue an RXDATA read landing on the 8th-sample push.
    task automatic spi_bits(input logic [7:0] tx, input logic d,
                            input int nbits, input bit pp,
                            output logic [7:0] rxb,
                            output logic [31:0] pq, output logic pd);
        rxb = '0; pq = '0; pd = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha_m) begin
                mosi = tx[7-i]; dc = d;
                wait_n(H);
                sclk = ~cpol_m;
                rxb = {rxb[6:0], miso};
                if (pp && i == 7) begin
                    wait_n(2);
                    bus.rd = 1'b1; bus.addr = REG_RXDATA;
                    @(posedge clk); #1;
                    pq = bus.rdat; pd = bus.done;
                    bus.rd = 1'b0;
                    wait_n(H - 2);
                end else begin
                    wait_n(H);
                end
                sclk = cpol_m;
            end else begin
                sclk = ~cpol_m;
                mosi = tx[7-i]; dc = d;
                wait_n(H);
                sclk = cpol_m;
                rxb = {rxb[6:0], miso};
                wait_n(H);
            end
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, input logic d,
                            output logic [7:0] rxb);
        logic [31:0] a;
        logic        b;
        spi_bits(tx, d, 8, 1'b0, rxb, a, b);
    endtask

    initial begin
        bus.wr = 0; bus.rd = 0; bus.addr = '0; bus.wdat = '0;
        cs = 1; sclk = 1; mosi = 0; dc = 0;
        cpol_m = 1; cpha_m = 1;
        reset = 1;
        wait_n(3);
        chk("rst_miso", miso, 0);
        chk("rst_oe", miso_oe, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rdat", bus.rdat, 0);
        reset = 0;
        wait_n(2);
        rd_chk("st_rst", REG_STATUS, 32'h0);
        rd_chk("mode_rst", REG_MODE, 32'h3);
        rd_chk("rx_empty0", REG_RXDATA, RX_EMPTY_FLAG);
        rd_chk("bad_off", 8'h10, 32'h0);

        // mode 3, two bytes under one cs
        cs_lo();
        chk("oe_lo", miso_oe, 1);
        rd_chk("st_cs", REG_STATUS, 32'h1200);
        spi_byte(8'hA5, 1'b1, rx);
        chk("miso_ff_m3", rx, 8'hFF);
        spi_byte(8'h3C, 1'b0, rx);
        cs_hi();
        chk("oe_hi", miso_oe, 0);
        rd_chk("st_two", REG_STATUS, 32'h0202);
        rd_chk("rx_a5", REG_RXDATA, 32'h1A5);
        rd_chk("rx_3c", REG_RXDATA, 32'h03C);
        rd_chk("rx_empty1", REG_RXDATA, RX_EMPTY_FLAG);
        wr_reg(REG_STATUS, 32'h700);
        @(posedge clk); #1;
        chk("done_pulse", bus.done, 0);
        rd_chk("st_clr", REG_STATUS, 32'h0);

        // mode 0 transmit
        bus_xact(1'b1, 1'b1, REG_MODE, 32'h0, q);
        chk("wr_rd_both", q, 32'h0);
        rd_chk("mode0", REG_MODE, 32'h0);
        cpol_m = 0; cpha_m = 0; sclk = 0;
        wait_n(4);
        wr_reg(REG_TXDATA, 32'h96);
        rd_chk("st_txv", REG_STATUS, 32'h0800);
        cs_lo();
        spi_byte(8'h11, 1'b0, rx);
        chk("miso_96", rx, 8'h96);
        rd_chk("st_txv0", REG_STATUS, 32'h1201);
        spi_byte(8'h22, 1'b1, rx);
        chk("miso_ff_m0", rx, 8'hFF);
        cs_hi();
        rd_chk("st_udr", REG_STATUS, 32'h0202);
        rd_chk("rx_11", REG_RXDATA, 32'h011);
        rd_chk("rx_22", REG_RXDATA, 32'h122);
        wr_reg(REG_STATUS, 32'h700);

        // overflow: 17 bytes into 16 entries
        cs_lo();
        for (int i = 0; i < 17; i++) begin
            spi_byte(8'(8'h40 + i), 1'(i % 2), rx);
        end
        cs_hi();
        rd_chk("st_ovf", REG_STATUS, 32'h0310);
        wr_reg(REG_STATUS, 32'h100);
        rd_chk("st_ovf_clr", REG_STATUS, 32'h0210);

        // push and pop in the same cycle while full
        cs_lo();
        spi_bits(8'h5A, 1'b1, 8, 1'b1, rx, ppq, ppd);
        chk("pp_done", ppd, 1);
        chk("pp_data", ppq, 32'h040);
        cs_hi();
        rd_chk("st_pp", REG_STATUS, 32'h0210);
        for (int i = 1; i < 16; i++) begin
            rd_chk("rx_drain", REG_RXDATA, 32'((i % 2) * 256 + 64 + i));
        end
        rd_chk("rx_5a", REG_RXDATA, 32'h15A);
        rd_chk("rx_empty2", REG_RXDATA, RX_EMPTY_FLAG);

        // partial byte then a clean one
        wr_reg(REG_STATUS, 32'h700);
        cs_lo();
        spi_bits(8'hF0, 1'b0, 5, 1'b0, rx, ppq, ppd);
        cs_hi();
        rd_chk("st_prt", REG_STATUS, 32'h0600);
        rd_chk("rx_none", REG_RXDATA, RX_EMPTY_FLAG);
        cs_lo();
        spi_byte(8'hC3, 1'b1, rx);
        cs_hi();
        rd_chk("rx_c3", REG_RXDATA, 32'h1C3);

        // asynchronous reset mid-byte with 3 entries queued
        cs_lo();
        spi_byte(8'h01, 1'b0, rx);
        spi_byte(8'h02, 1'b0, rx);
        spi_byte(8'h03, 1'b0, rx);
        spi_bits(8'h77, 1'b0, 3, 1'b0, rx, ppq, ppd);
        chk("pre_miso", miso, 1);
        chk("pre_oe", miso_oe, 1);
        #2 reset = 1;
        #1;
        chk("arst_miso", miso, 0);
        chk("arst_oe", miso_oe, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_rdat", bus.rdat, 0);
        cs = 1; sclk = 1; cpol_m = 1; cpha_m = 1;
        wait_n(2);
        reset = 0;
        wait_n(H);
        rd_chk("st_arst", REG_STATUS, 32'h0);
        rd_chk("mode_arst", REG_MODE, 32'h3);
        rd_chk("rx_arst", REG_RXDATA, RX_EMPTY_FLAG);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
